alu_packet_proc: RTL and testbench
==================================

# alu_packet_proc

Packet-level command processor between the UART receiver and the UART transmitter. It consumes received bytes over an 8-bit AXI-Stream slave and parses framed commands: echo, 32-bit add and 32-bit multiply. It drives the response bytes over an 8-bit AXI-Stream master into the transmitter. It replaces the direct rx-to-tx loopback and adds no clock-domain logic.

## Interface
- Parameters:
- `MulCycles`, default 32: iterations of the sequential multiplier; fixed at 32 for 32-bit operands.
- Ports:
- `clk_i`  in  1  system clock (32.256 MHz).
- `rst_i`  in  1  reset; asynchronous assert, active-high. One clock; no other reset exists.
- `s_axis_tdata`  in  8  byte from the UART receiver.
- `s_axis_tvalid`  in  1  receiver byte valid.
- `s_axis_tready`  out  1  processor accepts the byte.
- `m_axis_tdata`  out  8  response byte to the UART transmitter.
- `m_axis_tvalid`  out  1  response byte valid.
- `m_axis_tready`  in  1  transmitter accepts the byte.

## Operation
- Packet format: opcode, reserved, len_lo, len_hi, then payload.
  - `len` is a 16-bit little-endian total packet length, header included.
  - Operands are 32-bit little-endian.
- Opcodes, from `alu_pkg`:
  - `OP_ECHO`=0xEC
  - `OP_ADD`=0xAD
  - `OP_MUL`=0x88
- FSM states:
  - `S_OPCODE`, `S_RSVD`, `S_LEN_LO`, `S_LEN_HI`: header capture, one byte each.
  - `S_ECHO`, `S_OPERAND`, `S_MUL_WAIT`, `S_RESULT`, `S_DISCARD`.
- After `S_LEN_HI`, with payload count p = len − 4 (p ≤ 0 means no payload):
  - ECHO, p > 0: go to `S_ECHO`. ECHO, p ≤ 0: go to `S_OPCODE` with no output.
  - ADD/MUL, p ≥ 4 and p % 4 == 0: go to `S_OPERAND`.
  - Otherwise, including an unknown opcode: go to `S_DISCARD` for p bytes (`S_OPCODE` if p ≤ 0). No output is produced.
- `S_ECHO`: each payload byte is copied to the output register. Return to `S_OPCODE` after p bytes.
- `S_OPERAND`: bytes are shifted into a 32-bit operand register.
  - On every 4th byte, the first operand loads the accumulator.
  - Each later operand: ADD sets acc = acc + op (mod 2^32). MUL starts `mul32_seq` and enters `S_MUL_WAIT`.
  - After the last operand: ADD goes to `S_RESULT`. MUL goes to `S_RESULT` when the multiplier finishes.
- `S_MUL_WAIT`: wait for `done`; acc = low 32 bits of the product. Then go back to `S_OPERAND`, or to `S_RESULT` if that was the last operand.
- `S_RESULT`: emit acc as 4 bytes, LSB first, then go to `S_OPCODE`.
- A 16-bit remaining-byte counter tracks the payload. It is loaded with p and decremented per accepted byte. No wrap is possible because it is loaded only when p > 0.

## Timing
- Reset values: `s_axis_tready`=0, `m_axis_tvalid`=0, `m_axis_tdata`=0x00, state `S_OPCODE`, all counters and acc zero.
  - `s_axis_tready` rises on the first clock after reset deasserts.
  - Reset asserted mid-packet aborts immediately. No partial output is produced, and the next byte is parsed as an opcode.
- `s_axis_tready`:
  - `S_OPCODE`, `S_RSVD`, `S_LEN_LO`, `S_LEN_HI`, `S_OPERAND`, `S_DISCARD`: 1.
  - `S_ECHO`: `!m_axis_tvalid || m_axis_tready`.
  - `S_MUL_WAIT` and `S_RESULT`: 0.
- Output is a single registered stage.
  - `m_axis_tdata` stays stable while `tvalid && !tready`.
  - `tvalid` is never dropped without a handshake.
- Echo latency: the byte appears on `m_axis_tdata` one cycle after it is accepted. Full throughput is 1 byte/cycle when the sink is ready.
- ADD latency: `m_axis_tvalid` rises 1 cycle after the last operand byte is accepted.
- MUL latency:
  - `mul32_seq` start is registered 1 cycle after the 4th byte; `done` follows `MulCycles` cycles later.
  - The first result byte is valid exactly 34 cycles after the final operand byte is accepted.
- Simultaneous handshakes: in `S_ECHO`, when the sink consumes the held byte in the same cycle a new byte is accepted, the register reloads with no bubble.

## Structure
- `alu_pkg` holds:
  - `opcode_e` (8-bit enum), `state_e`
  - `HdrBytes`=4, `OperandBytes`=4
- Sub-module `mul32_seq`: shift-add multiplier.
  - Inputs: `clk_i`, `rst_i`, `start_i`, `a_i[31:0]`, `b_i[31:0]`.
  - Outputs: `done_o` (1-cycle pulse), `p_o[31:0]` (low product bits).
  - Busy exactly `MulCycles` cycles.

## Test plan
- Echo: EC 00 07 00 41 42 43 -> output 41 42 43, then idle.
- Add wrap: AD 00 0C 00 01 00 00 00 FF FF FF FF -> output 00 00 00 00.
- Multiply: 88 00 10 00 03 00 00 00 05 00 00 00 02 00 00 00 -> output 1E 00 00 00.
  - `s_axis_tready` is low for 34 cycles after each later operand.
- Bad input:
  - Unknown opcode: 55 00 06 00 AA BB.
  - Then the length-mismatched ADD AD 00 07 00 11 22 33.
  - Then AD 00 08 00 78 56 34 12 -> only output 78 56 34 12.
- Backpressure: during an echo of 16 bytes 0x00..0x0F, hold `m_axis_tready` low for 10 cycles mid-stream.
  - Required: `s_axis_tready` drops and all 16 bytes arrive in order.
- Reset during `S_MUL_WAIT`: assert `rst_i` for 1 cycle.
  - Required: `m_axis_tvalid` goes to 0 immediately and no result is emitted.
  - A following ADD packet is processed correctly.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and constants for the packet-level ALU command processor.
package alu_pkg;

   localparam int HdrBytes     = 4;
   localparam int OperandBytes = 4;

   typedef enum logic [7:0] {
      OP_ECHO = 8'hEC,
      OP_ADD  = 8'hAD,
      OP_MUL  = 8'h88
   } opcode_e;

   typedef enum logic [3:0] {
      S_OPCODE,
      S_RSVD,
      S_LEN_LO,
      S_LEN_HI,
      S_ECHO,
      S_OPERAND,
      S_MUL_WAIT,
      S_RESULT,
      S_DISCARD
   } state_e;

   // Byte lane of a 32-bit word, lane 0 is the least significant byte.
   function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] idx);
      logic [7:0] b;
      case (idx)
         2'd0:    b = w[7:0];
         2'd1:    b = w[15:8];
         2'd2:    b = w[23:16];
         default: b = w[31:24];
      endcase
      return b;
   endfunction

endpackage

// File: rtl/mul32_seq.sv
// Sequential shift-add multiplier, low 32 product bits.
// The start cycle already performs the first partial-product step, so the
// unit is busy for exactly MulCycles cycles and done_o pulses on the last one.
module mul32_seq #(
   parameter int MulCycles = 32
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   output logic        done_o,
   output logic [31:0] p_o
);

   localparam int CntW = $clog2(MulCycles + 1);

   logic [31:0]     a_sh;
   logic [31:0]     b_sh;
   logic [31:0]     prod;
   logic [CntW-1:0] cnt;
   logic            busy;

   assign p_o = prod;

   // One multiplier bit per cycle; done_o is a single-cycle pulse.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         a_sh   <= '0;
         b_sh   <= '0;
         prod   <= '0;
         cnt    <= '0;
         busy   <= 1'b0;
         done_o <= 1'b0;
      end else begin
         done_o <= 1'b0;
         if (start_i) begin
            prod <= b_i[0] ? a_i : '0;
            a_sh <= a_i << 1;
            b_sh <= b_i >> 1;
            cnt  <= CntW'(MulCycles - 1);
            busy <= 1'b1;
         end else if (busy) begin
            if (b_sh[0]) prod <= prod + a_sh;
            a_sh <= a_sh << 1;
            b_sh <= b_sh >> 1;
            cnt  <= cnt - CntW'(1);
            if (cnt == CntW'(1)) begin
               busy   <= 1'b0;
               done_o <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/alu_packet_proc.sv
// Packet command processor between UART rx and tx byte streams.
//
//  state      | meaning
//  -----------+-----------------------------------------------------------
//  S_OPCODE   | waiting for the opcode byte of a new packet
//  S_RSVD     | skipping the reserved header byte
//  S_LEN_LO   | capturing the low byte of the total packet length
//  S_LEN_HI   | capturing the high byte, choosing how to treat the payload
//  S_ECHO     | copying payload bytes straight to the output register
//  S_OPERAND  | assembling 32-bit little-endian operands, folding ADD
//  S_MUL_WAIT | input stalled while the sequential multiplier runs
//  S_RESULT   | emitting the accumulator LSB first
//  S_DISCARD  | dropping the payload of a malformed or unknown packet
module alu_packet_proc
   import alu_pkg::*;
#(
   parameter int MulCycles = 32
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [7:0] s_axis_tdata,
   input  logic       s_axis_tvalid,
   output logic       s_axis_tready,
   output logic [7:0] m_axis_tdata,
   output logic       m_axis_tvalid,
   input  logic       m_axis_tready
);

   state_e      state;
   logic        run_q;
   logic [7:0]  opcode_q;
   logic [7:0]  len_lo_q;
   logic [15:0] rem_q;
   logic [1:0]  byte_idx_q;
   logic        first_op_q;
   logic        last_op_q;
   logic [31:0] operand_q;
   logic [31:0] acc_q;
   logic [1:0]  res_idx_q;
   logic        mul_start_q;

   logic        mul_done;
   logic [31:0] mul_p;

   logic        out_free;
   logic        in_fire;
   logic [15:0] hdr_len;
   logic [15:0] pay_len;
   logic        has_payload;
   logic        ops_ok;
   logic        is_arith;
   logic [31:0] word_in;
   logic        go_res;
   logic [31:0] res_val;

   assign out_free    = !m_axis_tvalid || m_axis_tready;
   assign in_fire     = s_axis_tvalid && s_axis_tready;
   assign hdr_len     = {s_axis_tdata, len_lo_q};
   assign pay_len     = hdr_len - 16'(HdrBytes);
   assign has_payload = hdr_len > 16'(HdrBytes);
   assign ops_ok      = has_payload && ((pay_len % 16'(OperandBytes)) == 16'd0);
   assign is_arith    = (opcode_q == OP_ADD) || (opcode_q == OP_MUL);
   assign word_in     = {s_axis_tdata, operand_q[31:8]};

   mul32_seq #(.MulCycles(MulCycles)) u_mul (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .start_i (mul_start_q),
      .a_i     (acc_q),
      .b_i     (operand_q),
      .done_o  (mul_done),
      .p_o     (mul_p)
   );

   // Input acceptance: echo only advances when the output register can take the byte.
   always_comb begin
      s_axis_tready = 1'b0;
      if (run_q) begin
         case (state)
            S_ECHO:               s_axis_tready = out_free;
            S_MUL_WAIT, S_RESULT: s_axis_tready = 1'b0;
            default:              s_axis_tready = 1'b1;
         endcase
      end
   end

   // Detect the cycle in which the final accumulator value becomes known.
   always_comb begin
      go_res  = 1'b0;
      res_val = acc_q;
      case (state)
         S_OPERAND: begin
            if (in_fire && byte_idx_q == 2'd3 && rem_q == 16'd1 &&
                (first_op_q || opcode_q == OP_ADD)) begin
               go_res  = 1'b1;
               res_val = first_op_q ? word_in : acc_q + word_in;
            end
         end
         S_MUL_WAIT: begin
            if (mul_done && last_op_q) begin
               go_res  = 1'b1;
               res_val = mul_p;
            end
         end
         default: ;
      endcase
   end

   // Packet parser, accumulator and output register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state         <= S_OPCODE;
         run_q         <= 1'b0;
         opcode_q      <= '0;
         len_lo_q      <= '0;
         rem_q         <= '0;
         byte_idx_q    <= '0;
         first_op_q    <= 1'b0;
         last_op_q     <= 1'b0;
         operand_q     <= '0;
         acc_q         <= '0;
         res_idx_q     <= '0;
         mul_start_q   <= 1'b0;
         m_axis_tdata  <= '0;
         m_axis_tvalid <= 1'b0;
      end else begin
         run_q       <= 1'b1;
         mul_start_q <= 1'b0;
         if (m_axis_tvalid && m_axis_tready) m_axis_tvalid <= 1'b0;

         if (go_res) begin
            // First result byte goes out immediately if the output register is free.
            acc_q <= res_val;
            state <= S_RESULT;
            if (state == S_OPERAND) rem_q <= rem_q - 16'd1;
            if (out_free) begin
               m_axis_tdata  <= res_val[7:0];
               m_axis_tvalid <= 1'b1;
               res_idx_q     <= 2'd1;
            end else begin
               res_idx_q <= 2'd0;
            end
         end else begin
            case (state)
               S_OPCODE: begin
                  if (in_fire) begin
                     opcode_q <= s_axis_tdata;
                     state    <= S_RSVD;
                  end
               end
               S_RSVD: begin
                  if (in_fire) state <= S_LEN_LO;
               end
               S_LEN_LO: begin
                  if (in_fire) begin
                     len_lo_q <= s_axis_tdata;
                     state    <= S_LEN_HI;
                  end
               end
               S_LEN_HI: begin
                  if (in_fire) begin
                     byte_idx_q <= 2'd0;
                     first_op_q <= 1'b1;
                     last_op_q  <= 1'b0;
                     if (has_payload) rem_q <= pay_len;
                     if (!has_payload)                state <= S_OPCODE;
                     else if (opcode_q == OP_ECHO)    state <= S_ECHO;
                     else if (is_arith && ops_ok)     state <= S_OPERAND;
                     else                             state <= S_DISCARD;
                  end
               end
               S_ECHO: begin
                  if (in_fire) begin
                     m_axis_tdata  <= s_axis_tdata;
                     m_axis_tvalid <= 1'b1;
                     rem_q         <= rem_q - 16'd1;
                     if (rem_q == 16'd1) state <= S_OPCODE;
                  end
               end
               S_OPERAND: begin
                  if (in_fire) begin
                     operand_q  <= word_in;
                     rem_q      <= rem_q - 16'd1;
                     byte_idx_q <= byte_idx_q + 2'd1;
                     if (byte_idx_q == 2'd3) begin
                        last_op_q <= (rem_q == 16'd1);
                        if (first_op_q) begin
                           acc_q      <= word_in;
                           first_op_q <= 1'b0;
                        end else if (opcode_q == OP_ADD) begin
                           acc_q <= acc_q + word_in;
                        end else begin
                           mul_start_q <= 1'b1;
                           state       <= S_MUL_WAIT;
                        end
                     end
                  end
               end
               S_MUL_WAIT: begin
                  if (mul_done) begin
                     acc_q <= mul_p;
                     state <= S_OPERAND;
                  end
               end
               S_RESULT: begin
                  if (out_free) begin
                     m_axis_tdata  <= byte_of(acc_q, res_idx_q);
                     m_axis_tvalid <= 1'b1;
                     res_idx_q     <= res_idx_q + 2'd1;
                     if (res_idx_q == 2'd3) state <= S_OPCODE;
                  end
               end
               S_DISCARD: begin
                  if (in_fire) begin
                     rem_q <= rem_q - 16'd1;
                     if (rem_q == 16'd1) state <= S_OPCODE;
                  end
               end
               default: state <= S_OPCODE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_alu_packet_proc.sv
// Directed bench for alu_packet_proc with a packet-level reference model and
// an output scoreboard checked on every output handshake.
module tb_alu_packet_proc;

   typedef logic [7:0] bq_t [$];

   logic       clk_i         = 1'b0;
   logic       rst_i         = 1'b1;
   logic [7:0] s_axis_tdata  = 8'h00;
   logic       s_axis_tvalid = 1'b0;
   logic       s_axis_tready;
   logic [7:0] m_axis_tdata;
   logic       m_axis_tvalid;
   logic       m_axis_tready = 1'b1;

   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   int   acc_cyc  = 0;
   bq_t  exp_q;
   logic hold_q   = 1'b0;
   logic [7:0] held = 8'h00;

   alu_packet_proc #(.MulCycles(32)) dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready)
   );

   always #5 clk_i = ~clk_i;

   always @(posedge clk_i) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Expected response of one complete packet, straight from the packet rules.
   function automatic void model(input bq_t pkt, output bq_t out);
      int len;
      int p;
      logic [63:0] acc;
      logic [63:0] w;
      out = {};
      len = int'({pkt[3], pkt[2]});
      p   = len - 4;
      acc = 64'd0;
      if (pkt[0] == 8'hEC) begin
         for (int i = 0; i < p; i++) out.push_back(pkt[4 + i]);
      end else if ((pkt[0] == 8'hAD || pkt[0] == 8'h88) && p >= 4 && (p % 4) == 0) begin
         for (int k = 0; k < p / 4; k++) begin
            w = {32'd0, pkt[4*k+7], pkt[4*k+6], pkt[4*k+5], pkt[4*k+4]};
            if (k == 0)              acc = w;
            else if (pkt[0] == 8'hAD) acc = (acc + w) & 64'hFFFF_FFFF;
            else                     acc = (acc * w) & 64'hFFFF_FFFF;
         end
         for (int b = 0; b < 4; b++) out.push_back(8'(acc >> (8 * b)));
      end
   endfunction

   // Scoreboard: every output handshake must match the next expected byte,
   // and a stalled byte must stay put.
   always @(negedge clk_i) begin
      logic [7:0] e;
      if (rst_i) begin
         hold_q = 1'b0;
      end else begin
         if (hold_q) begin
            n_checks++;
            if (!(m_axis_tvalid === 1'b1 && m_axis_tdata === held)) begin
               n_fail++;
               $display("FAIL hold_stable: got valid=%0b data=%02h, expected valid=1 data=%02h",
                        m_axis_tvalid, m_axis_tdata, held);
            end
         end
         if (m_axis_tvalid && m_axis_tready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_byte: got %02h, expected no output", m_axis_tdata);
            end else begin
               e = exp_q.pop_front();
               if (m_axis_tdata !== e) begin
                  n_fail++;
                  $display("FAIL out_byte: got %02h, expected %02h", m_axis_tdata, e);
               end
            end
         end
         hold_q = m_axis_tvalid && !m_axis_tready;
         held   = m_axis_tdata;
      end
   end

   task automatic send_byte(input logic [7:0] b);
      logic rdy;
      bit   ok;
      ok = 1'b0;
      @(negedge clk_i);
      s_axis_tdata  = b;
      s_axis_tvalid = 1'b1;
      for (int n = 0; n < 2000 && !ok; n++) begin
         #1 rdy = s_axis_tready;
         @(posedge clk_i);
         if (rdy) ok = 1'b1;
         else @(negedge clk_i);
      end
      #1;
      acc_cyc       = cyc;
      s_axis_tvalid = 1'b0;
      if (!ok) begin
         n_checks++;
         n_fail++;
         $display("FAIL send_timeout: byte %02h not accepted, expected acceptance", b);
      end
   endtask

   task automatic send_packet(input bq_t pkt);
      bq_t out;
      model(pkt, out);
      foreach (out[i]) exp_q.push_back(out[i]);
      foreach (pkt[i]) send_byte(pkt[i]);
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 300) begin
         @(negedge clk_i);
         n++;
      end
      repeat (3) @(negedge clk_i);
      check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
      check({name, "_idle"}, 64'(m_axis_tvalid), 64'd0);
   endtask

   // Cycles from the accepting edge of the last byte until tvalid is seen
   // (1 means visible right after that edge).
   task automatic wait_valid(output int lat);
      lat = -1;
      for (int n = 0; n < 200; n++) begin
         @(negedge clk_i);
         if (m_axis_tvalid) begin
            lat = cyc - acc_cyc + 1;
            break;
         end
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bq_t pkt;
      bq_t out;
      int  lat;
      int  a_cyc;

      // Reset values and tready release.
      repeat (3) @(negedge clk_i);
      check("rst_s_tready", 64'(s_axis_tready), 64'd0);
      check("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
      check("rst_m_tdata",  64'(m_axis_tdata),  64'd0);
      rst_i = 1'b0;
      #1 check("s_tready_before_clk", 64'(s_axis_tready), 64'd0);
      @(posedge clk_i);
      #1 check("s_tready_after_clk", 64'(s_axis_tready), 64'd1);

      // Pin the model with hand-computed results.
      pkt = '{8'hEC, 8'h00, 8'h07, 8'h00, 8'h41, 8'h42, 8'h43};
      model(pkt, out);
      check("model_echo_n", 64'(out.size()), 64'd3);
      check("model_echo", {40'd0, out[0], out[1], out[2]}, 64'h41_42_43);
      pkt = '{8'hAD, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00,
              8'hFF, 8'hFF, 8'hFF, 8'hFF};
      model(pkt, out);
      check("model_add_wrap", {31'd0, 1'b1, out[3], out[2], out[1], out[0]}, 64'h1_0000_0000);
      pkt = '{8'h88, 8'h00, 8'h10, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00,
              8'h05, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00};
      model(pkt, out);
      check("model_mul", {32'd0, out[3], out[2], out[1], out[0]}, 64'h0000_001E);
      pkt = '{8'hAD, 8'h00, 8'h07, 8'h00, 8'h11, 8'h22, 8'h33};
      model(pkt, out);
      check("model_bad_len_n", 64'(out.size()), 64'd0);

      // Echo: last byte visible the cycle after acceptance.
      pkt = '{8'hEC, 8'h00, 8'h07, 8'h00, 8'h41, 8'h42, 8'h43};
      send_packet(pkt);
      @(negedge clk_i);
      check("echo_last_latency", {55'd0, m_axis_tvalid, m_axis_tdata}, {55'd0, 1'b1, 8'h43});
      drain("echo");

      // Echo with no payload produces nothing.
      pkt = '{8'hEC, 8'h00, 8'h04, 8'h00};
      send_packet(pkt);
      drain("echo_empty");

      // Add with 32-bit wrap, latency of one cycle.
      pkt = '{8'hAD, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00,
              8'hFF, 8'hFF, 8'hFF, 8'hFF};
      send_packet(pkt);
      wait_valid(lat);
      check("add_latency", 64'(lat), 64'd1);
      drain("add_wrap");

      // Multiply chain 3*5*2, sent byte by byte to measure stall and latency.
      pkt = '{8'h88, 8'h00, 8'h10, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00,
              8'h05, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00};
      model(pkt, out);
      foreach (out[i]) exp_q.push_back(out[i]);
      for (int i = 0; i < 12; i++) send_byte(pkt[i]);
      a_cyc = acc_cyc;
      send_byte(pkt[12]);
      check("mul_stall_gap", 64'(acc_cyc - a_cyc), 64'd34);
      for (int i = 13; i < 16; i++) send_byte(pkt[i]);
      wait_valid(lat);
      check("mul_latency", 64'(lat), 64'd34);
      drain("mul");

      // Bad packets, then a single-operand add.
      pkt = '{8'h55, 8'h00, 8'h06, 8'h00, 8'hAA, 8'hBB};
      send_packet(pkt);
      pkt = '{8'hAD, 8'h00, 8'h07, 8'h00, 8'h11, 8'h22, 8'h33};
      send_packet(pkt);
      pkt = '{8'hAD, 8'h00, 8'h08, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
      send_packet(pkt);
      wait_valid(lat);
      check("single_add_latency", 64'(lat), 64'd1);
      drain("bad_input");

      // Echo of 16 bytes with the sink stalled for 10 cycles mid-stream.
      pkt = '{8'hEC, 8'h00, 8'h14, 8'h00};
      for (int i = 0; i < 16; i++) pkt.push_back(8'(i));
      fork
         send_packet(pkt);
         begin
            repeat (8) @(negedge clk_i);
            m_axis_tready = 1'b0;
            repeat (3) @(negedge clk_i);
            check("bp_s_tready_low", 64'(s_axis_tready), 64'd0);
            repeat (7) @(negedge clk_i);
            m_axis_tready = 1'b1;
         end
      join
      drain("backpressure");

      // Reset while the multiplier is busy: no result, parser restarts.
      pkt = '{8'h88, 8'h00, 8'h0C, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00,
              8'h05, 8'h00, 8'h00, 8'h00};
      foreach (pkt[i]) send_byte(pkt[i]);
      repeat (5) @(negedge clk_i);
      rst_i = 1'b1;
      #1 check("rst_mid_m_tvalid", 64'(m_axis_tvalid), 64'd0);
      check("rst_mid_s_tready", 64'(s_axis_tready), 64'd0);
      @(negedge clk_i);
      rst_i = 1'b0;
      lat = 0;
      for (int n = 0; n < 50; n++) begin
         @(negedge clk_i);
         if (m_axis_tvalid) lat++;
      end
      check("rst_no_result", 64'(lat), 64'd0);
      pkt = '{8'hAD, 8'h00, 8'h0C, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00,
              8'h20, 8'h00, 8'h00, 8'h00};
      send_packet(pkt);
      drain("post_reset_add");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
